paralelo_serial_tx: RTL

Transmit-side parallel-to-serial converter of the PHY. It accepts 8-bit bytes through a valid/ready handshake and serialises them MSB-first on `clk_32f`, one bit per cycle, into the serial line consumed by `serial_paralelo_rx`. When no data is pending it transmits the K28.5 comma byte 0xBC. After reset it sends a fixed burst of commas so the receiver can align and go active.

---
 rtl/paralelo_serial_tx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/paralelo_serial_tx.sv
// -----------------------------------------------------------------------------
// paralelo_serial_tx
//
// Transmit-side parallel-to-serial converter. Accepts bytes over a valid/ready
// handshake into a one-entry holding buffer and shifts them out MSB-first, one
// bit per clk_32f cycle. When nothing is pending the K28.5 comma (0xBC) is
// sent. After reset a burst of SYNC_BC commas is transmitted before the data
// path opens, so the receiver can align.
//
// Optional feature macro: PS_TX_STATS_EN
//   defined   -> output port bytes_sent[15:0] counts data bytes loaded
//                into the shifter (commas excluded), wrapping at 0xFFFF.
//   undefined -> no bytes_sent port and no counter.
// -----------------------------------------------------------------------------
module paralelo_serial_tx #(
   parameter int unsigned SYNC_BC = 4
) (
   input  logic        clk_32f,
   input  logic        reset_L,
   input  logic [7:0]  data_in,
   input  logic        valid_in,
   output logic        ready_out,
   output logic        data_out,
   output logic        active_out
`ifdef PS_TX_STATS_EN
   ,
   output logic [15:0] bytes_sent
`endif
);

   // Comma character used for alignment and as idle fill.
   localparam logic [7:0] COMMA_BYTE = 8'hBC;

   // Burst length trimmed to the width of the comma counter (range 1..15).
   localparam logic [3:0] SYNC_BC_L = SYNC_BC[3:0];

   typedef enum logic {
      ST_SYNC   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   state_t       state_q;
   logic [7:0]   cur_byte_q;
   logic [2:0]   bit_cnt_q;
   logic [7:0]   hold_q;
   logic         hold_valid_q;
   logic [3:0]   bc_cnt_q;

   logic         boundary_s;
   logic         transfer_s;
   logic         serial_bit_s;
   logic [3:0]   bc_cnt_d;
   logic         sync_done_s;

   // Handshake and status derive from registers only, never from valid_in.
   assign ready_out  = (state_q == ST_ACTIVE) && !hold_valid_q;
   assign active_out = (state_q == ST_ACTIVE);

   // Decode the per-edge events: byte boundary, input transfer, bit to emit.
   always_comb begin
      boundary_s   = (bit_cnt_q == 3'd7);
      transfer_s   = valid_in && ready_out;
      serial_bit_s = cur_byte_q[3'd7 - bit_cnt_q];
      bc_cnt_d     = bc_cnt_q + 4'd1;
      // ">=" keeps a burst length of 1 meaningful: the reset comma alone
      // completes the burst at the first boundary.
      if (bc_cnt_d >= SYNC_BC_L) begin
         sync_done_s = 1'b1;
      end else begin
         sync_done_s = 1'b0;
      end
   end

   // Sync/active sequencing, bit shifter, holding buffer and registered line.
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         state_q      <= ST_SYNC;
         cur_byte_q   <= COMMA_BYTE;
         bit_cnt_q    <= 3'd0;
         hold_q       <= 8'h00;
         hold_valid_q <= 1'b0;
         bc_cnt_q     <= 4'd1;
         data_out     <= 1'b0;
`ifdef PS_TX_STATS_EN
         bytes_sent   <= 16'd0;
`endif
      end else begin
         data_out  <= serial_bit_s;
         bit_cnt_q <= bit_cnt_q + 3'd1;

         // A transfer only happens with the buffer empty, so it can never
         // collide with the boundary drain below; the boundary always sees
         // the pre-edge buffer and there is no bypass to the shifter.
         if (transfer_s) begin
            hold_q       <= data_in;
            hold_valid_q <= 1'b1;
         end else if (boundary_s && (state_q == ST_ACTIVE) && hold_valid_q) begin
            hold_valid_q <= 1'b0;
         end else begin
            hold_valid_q <= hold_valid_q;
         end

         if (boundary_s) begin
            case (state_q)
               ST_SYNC: begin
                  cur_byte_q <= COMMA_BYTE;
                  bc_cnt_q   <= bc_cnt_d;
                  if (sync_done_s) begin
                     state_q <= ST_ACTIVE;
                  end else begin
                     state_q <= ST_SYNC;
                  end
               end
               ST_ACTIVE: begin
                  if (hold_valid_q) begin
                     cur_byte_q <= hold_q;
`ifdef PS_TX_STATS_EN
                     bytes_sent <= bytes_sent + 16'd1;
`endif
                  end else begin
                     cur_byte_q <= COMMA_BYTE;
                  end
                  state_q <= ST_ACTIVE;
               end
               default: begin
                  state_q    <= ST_SYNC;
                  cur_byte_q <= COMMA_BYTE;
               end
            endcase
         end
      end
   end

endmodule
